// File: rtl/aso_pkg.sv
// rtl/aso_pkg.sv - shared constants and state encoding for the ASO spike detector blocks
package aso_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        FILL        = 3'd1,
        ACCUM       = 3'd2,
        COMPUTE_MUL = 3'd3,
        COMPUTE_SAT = 3'd4,
        RUN         = 3'd5
    } aso_state_e;

    // Training threshold used by the detector when nothing has been trained
    localparam int DEFAULT_THR    = 500;
    // Gain is unsigned Q4.4
    localparam int GAIN_FRAC_BITS = 4;
    localparam int SAMPLE_RATE_HZ = 2000;

endpackage

// File: rtl/aso_abs_diff.sv
// rtl/aso_abs_diff.sv - unsigned |a - b| of two signed samples, one bit wider than the inputs
module aso_abs_diff #(
    parameter int DATA_W = 16
) (
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic        [DATA_W:0]   abs_diff
);

    logic signed [DATA_W:0] diff;

    // Sign-extend before subtracting so the difference cannot overflow; the
    // magnitude of the worst case (2^DATA_W - 1) still fits unsigned in DATA_W+1.
    always_comb begin
        diff     = {a[DATA_W-1], a} - {b[DATA_W-1], b};
        abs_diff = diff[DATA_W] ? (DATA_W+1)'(-diff) : diff;
    end

endmodule

// File: rtl/aso_threshold_ctrl.sv
// rtl/aso_threshold_ctrl.sv - trains the ASO detector threshold from a window of amplitude-slope samples
module aso_threshold_ctrl
    import aso_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int TRAIN_LOG2  = 10,
    parameter int DEFAULT_THR = aso_pkg::DEFAULT_THR,
    parameter int MIN_THR     = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     sample_valid,
    input  logic signed [DATA_W-1:0] data_in,
    input  logic [7:0]               gain,
    output logic [DATA_W-1:0]        threshold_out,
    output logic                     threshold_valid,
    output logic                     det_enable,
    output logic                     busy,
    output logic [2:0]               state_out
);

    localparam int ABS_W      = DATA_W + 1;
    localparam int ACC_W      = ABS_W + TRAIN_LOG2;
    localparam int MEAN_W     = ABS_W;
    localparam int PROD_W     = MEAN_W + 8;
    localparam int T_W        = PROD_W - GAIN_FRAC_BITS;
    localparam int CNT_W      = TRAIN_LOG2 + 1;
    localparam int TRAIN_LAST = (1 << TRAIN_LOG2) - 1;
    localparam int MAX_THR    = (1 << (DATA_W - 1)) - 1;

    aso_state_e               state;
    // hist[0..2] = x[n-1], x[n-2], x[n-3]; the incoming data_in is x[n]
    logic signed [DATA_W-1:0] hist [0:2];
    logic [CNT_W-1:0]         cnt;
    logic [ACC_W-1:0]         acc;
    logic [PROD_W-1:0]        product;
    logic [ABS_W-1:0]         slope;
    logic [MEAN_W-1:0]        mean;
    logic [T_W-1:0]           t_val;
    logic [DATA_W-1:0]        sat_thr;

    aso_abs_diff #(
        .DATA_W   (DATA_W)
    ) u_abs_diff (
        .a        (data_in),
        .b        (hist[2]),
        .abs_diff (slope)
    );

    // Window length is a power of two, so the mean is a plain right shift
    assign mean = MEAN_W'(acc >> TRAIN_LOG2);

    // Drop the Q4.4 fraction, then saturate high and clamp low
    always_comb begin
        t_val = T_W'(product >> GAIN_FRAC_BITS);
        if (t_val > T_W'(MAX_THR)) begin
            sat_thr = DATA_W'(MAX_THR);
        end else if (t_val < T_W'(MIN_THR)) begin
            sat_thr = DATA_W'(MIN_THR);
        end else begin
            sat_thr = t_val[DATA_W-1:0];
        end
    end

    assign state_out = state;

    // Training FSM; start overrides everything and restarts from FILL with a
    // clean history, discarding any sample that arrives in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            hist[0]         <= '0;
            hist[1]         <= '0;
            hist[2]         <= '0;
            cnt             <= '0;
            acc             <= '0;
            product         <= '0;
            threshold_out   <= DATA_W'(DEFAULT_THR);
            threshold_valid <= 1'b0;
            det_enable      <= 1'b0;
            busy            <= 1'b0;
        end else if (start) begin
            state           <= FILL;
            hist[0]         <= '0;
            hist[1]         <= '0;
            hist[2]         <= '0;
            cnt             <= '0;
            acc             <= '0;
            product         <= '0;
            threshold_out   <= DATA_W'(DEFAULT_THR);
            threshold_valid <= 1'b0;
            det_enable      <= 1'b0;
            busy            <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                end
                FILL: begin
                    if (sample_valid) begin
                        hist[0] <= data_in;
                        hist[1] <= hist[0];
                        hist[2] <= hist[1];
                        if (cnt == CNT_W'(2)) begin
                            cnt   <= '0;
                            state <= ACCUM;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (sample_valid) begin
                        hist[0] <= data_in;
                        hist[1] <= hist[0];
                        hist[2] <= hist[1];
                        acc     <= acc + ACC_W'(slope);
                        if (cnt == CNT_W'(TRAIN_LAST)) begin
                            state <= COMPUTE_MUL;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                COMPUTE_MUL: begin
                    product <= PROD_W'(mean) * PROD_W'(gain);
                    state   <= COMPUTE_SAT;
                end
                COMPUTE_SAT: begin
                    threshold_out   <= sat_thr;
                    threshold_valid <= 1'b1;
                    det_enable      <= 1'b1;
                    busy            <= 1'b0;
                    state           <= RUN;
                end
                RUN: begin
                end
                default: begin
                    state           <= IDLE;
                    threshold_out   <= DATA_W'(DEFAULT_THR);
                    threshold_valid <= 1'b0;
                    det_enable      <= 1'b0;
                    busy            <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aso_threshold_ctrl.sv
// tb/tb_aso_threshold_ctrl.sv - directed self-checking bench for aso_threshold_ctrl
module tb_aso_threshold_ctrl;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic               sample_valid;
    logic signed [15:0] data_in;
    logic [7:0]         gain;
    logic [15:0]        threshold_out;
    logic               threshold_valid;
    logic               det_enable;
    logic               busy;
    logic [2:0]         state_out;

    int checks = 0;
    int errors = 0;

    aso_threshold_ctrl #(
        .DATA_W      (16),
        .TRAIN_LOG2  (4),
        .DEFAULT_THR (500),
        .MIN_THR     (16)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .sample_valid    (sample_valid),
        .data_in         (data_in),
        .gain            (gain),
        .threshold_out   (threshold_out),
        .threshold_valid (threshold_valid),
        .det_enable      (det_enable),
        .busy            (busy),
        .state_out       (state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Period-6 square wave: three samples at lo, three at hi, starting at index first
    task automatic feed(input int first, input int n, input int lo, input int hi, input int gap);
        for (int i = first; i < first + n; i++) begin
            sample_valid = 1'b1;
            data_in      = (((i / 3) % 2) != 0) ? 16'(hi) : 16'(lo);
            tick();
            sample_valid = 1'b0;
            for (int g = 0; g < gap + ((gap > 0 && (i % 5) == 0) ? 2 : 0); g++) tick();
        end
    endtask

    task automatic wait_run(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 8 && !ok; k++) begin
            if (threshold_valid) ok = 1'b1;
            else tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (20) tick();
        checks++; if (threshold_out !== 16'd500) begin errors++; $display("FAIL rst_thr: got %0d expected 500", threshold_out); end
        checks++; if (threshold_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b expected 0", threshold_valid); end
        checks++; if (det_enable !== 1'b0) begin errors++; $display("FAIL rst_en: got %0b expected 0", det_enable); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b expected 0", busy); end
        checks++; if (state_out !== 3'd0) begin errors++; $display("FAIL rst_state: got %0d expected 0", state_out); end
    endtask

    task automatic test_square_latency();
        gain = 8'h30;
        pulse_start();
        checks++; if (state_out !== 3'd1) begin errors++; $display("FAIL sq_fill: got %0d expected 1", state_out); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL sq_busy: got %0b expected 1", busy); end
        feed(0, 3, 0, 100, 0);
        checks++; if (state_out !== 3'd2) begin errors++; $display("FAIL sq_accum: got %0d expected 2", state_out); end
        feed(3, 15, 0, 100, 0);
        sample_valid = 1'b1;
        data_in      = 16'sd0;
        tick();
        sample_valid = 1'b0;
        checks++; if (state_out !== 3'd3 || threshold_valid !== 1'b0) begin errors++; $display("FAIL sq_lat1: got state %0d valid %0b expected state 3 valid 0", state_out, threshold_valid); end
        tick();
        checks++; if (state_out !== 3'd4 || threshold_valid !== 1'b0) begin errors++; $display("FAIL sq_lat2: got state %0d valid %0b expected state 4 valid 0", state_out, threshold_valid); end
        checks++; if (threshold_out !== 16'd500) begin errors++; $display("FAIL sq_thr_hold: got %0d expected 500", threshold_out); end
        tick();
        checks++; if (threshold_valid !== 1'b1) begin errors++; $display("FAIL sq_lat3: got %0b expected 1", threshold_valid); end
        checks++; if (threshold_out !== 16'd300) begin errors++; $display("FAIL sq_thr: got %0d expected 300", threshold_out); end
        checks++; if (det_enable !== 1'b1 || busy !== 1'b0 || state_out !== 3'd5) begin errors++; $display("FAIL sq_run: got en %0b busy %0b state %0d expected 1 0 5", det_enable, busy, state_out); end
    endtask

    task automatic test_gaps();
        bit ok;
        gain = 8'h30;
        pulse_start();
        checks++; if (threshold_out !== 16'd500 || threshold_valid !== 1'b0 || det_enable !== 1'b0) begin errors++; $display("FAIL gap_restart: got thr %0d valid %0b en %0b expected 500 0 0", threshold_out, threshold_valid, det_enable); end
        feed(0, 19, 0, 100, 1);
        wait_run(ok);
        checks++; if (!ok) begin errors++; $display("FAIL gap_timeout: got no valid expected valid"); end
        checks++; if (threshold_out !== 16'd300) begin errors++; $display("FAIL gap_thr: got %0d expected 300", threshold_out); end
    endtask

    task automatic test_clamp();
        bit ok;
        gain = 8'h10;
        pulse_start();
        feed(0, 19, 1234, 1234, 0);
        wait_run(ok);
        checks++; if (!ok || threshold_out !== 16'd16) begin errors++; $display("FAIL clamp_min: got %0d expected 16", threshold_out); end
        gain = 8'hF0;
        pulse_start();
        feed(0, 19, 0, 30000, 0);
        wait_run(ok);
        checks++; if (!ok || threshold_out !== 16'h7FFF) begin errors++; $display("FAIL clamp_max: got %0h expected 7fff", threshold_out); end
        gain = 8'h00;
        pulse_start();
        feed(0, 19, 0, 100, 0);
        wait_run(ok);
        checks++; if (!ok || threshold_out !== 16'd16) begin errors++; $display("FAIL gain_zero: got %0d expected 16", threshold_out); end
    endtask

    task automatic test_restart();
        bit ok;
        gain = 8'h10;
        pulse_start();
        feed(0, 13, 0, 1000, 0);
        checks++; if (state_out !== 3'd2) begin errors++; $display("FAIL rs_accum: got %0d expected 2", state_out); end
        start        = 1'b1;
        sample_valid = 1'b1;
        data_in      = 16'sd5000;
        tick();
        start        = 1'b0;
        sample_valid = 1'b0;
        checks++; if (state_out !== 3'd1) begin errors++; $display("FAIL rs_fill: got %0d expected 1", state_out); end
        feed(0, 19, 0, 100, 0);
        wait_run(ok);
        checks++; if (!ok || threshold_out !== 16'd100) begin errors++; $display("FAIL rs_thr: got %0d expected 100", threshold_out); end
        pulse_start();
        checks++; if (det_enable !== 1'b0 || threshold_valid !== 1'b0) begin errors++; $display("FAIL rs_run_en: got en %0b valid %0b expected 0 0", det_enable, threshold_valid); end
        checks++; if (threshold_out !== 16'd500) begin errors++; $display("FAIL rs_run_thr: got %0d expected 500", threshold_out); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        gain = 8'h20;
        pulse_start();
        feed(0, 19, 0, 100, 0);
        checks++; if (state_out !== 3'd3) begin errors++; $display("FAIL rm_mul: got %0d expected 3", state_out); end
        rst_n = 1'b0;
        #1;
        checks++; if (state_out !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL rm_async: got state %0d busy %0b expected 0 0", state_out, busy); end
        checks++; if (threshold_out !== 16'd500 || threshold_valid !== 1'b0 || det_enable !== 1'b0) begin errors++; $display("FAIL rm_outs: got thr %0d valid %0b en %0b expected 500 0 0", threshold_out, threshold_valid, det_enable); end
        tick();
        rst_n = 1'b1;
        repeat (20) tick();
        checks++; if (threshold_valid !== 1'b0 || state_out !== 3'd0) begin errors++; $display("FAIL rm_idle: got valid %0b state %0d expected 0 0", threshold_valid, state_out); end
        pulse_start();
        feed(0, 19, 0, 100, 0);
        wait_run(ok);
        checks++; if (!ok || threshold_out !== 16'd200) begin errors++; $display("FAIL rm_retrain: got %0d expected 200", threshold_out); end
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        sample_valid = 1'b0;
        data_in      = '0;
        gain         = 8'h10;
        test_reset();
        test_square_latency();
        test_gaps();
        test_clamp();
        test_restart();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
